// File: rtl/conv_out_tile_sequencer_if.sv
// rtl/conv_out_tile_sequencer_if.sv - tile origin/size and compute/drain handshake to conv core and output handler
interface conv_out_tile_sequencer_if #(
  parameter int CNT_W = 16
) ();
  logic [CNT_W-1:0] cur_ox_start, cur_oy_start, cur_of_start;
  logic [CNT_W-1:0] cur_pox, cur_poy, cur_pof;
  logic             compute_start, drain_start;
  logic             compute_done, out_done;

  modport master (
    output cur_ox_start, cur_oy_start, cur_of_start,
    output cur_pox, cur_poy, cur_pof,
    output compute_start, drain_start,
    input  compute_done, out_done
  );

  modport slave (
    input  cur_ox_start, cur_oy_start, cur_of_start,
    input  cur_pox, cur_poy, cur_pof,
    input  compute_start, drain_start,
    output compute_done, out_done
  );
endinterface

// File: rtl/conv_out_tile_sequencer.sv
// rtl/conv_out_tile_sequencer.sv - walks the conv output map tile by tile (of, ox, oy order); CONV_SEQ_PERF_CNT_EN adds perf counters
module conv_out_tile_sequencer #(
  parameter int CNT_W  = 16,
  parameter int PERF_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [CNT_W-1:0] out_x,
  input  logic [CNT_W-1:0] out_y,
  input  logic [CNT_W-1:0] out_f,
  input  logic [CNT_W-1:0] tile_x,
  input  logic [CNT_W-1:0] tile_y,
  input  logic [CNT_W-1:0] tile_f,
  conv_out_tile_sequencer_if.master tile,
  output logic             busy,
  output logic             done,
  output logic             cfg_err
`ifdef CONV_SEQ_PERF_CNT_EN
  ,
  output logic [PERF_W-1:0] perf_busy_cycles,
  output logic [PERF_W-1:0] perf_drain_cycles
`endif
);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_COMPUTE, S_DRAIN, S_ADVANCE, S_FIN} state_t;

  localparam logic [CNT_W-1:0] ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W:0]   ONE_W = {{CNT_W{1'b0}}, 1'b1};

  state_t           state, state_d;
  logic [CNT_W-1:0] lx, ly, lf, ltx, lty, ltf;
  logic [CNT_W-1:0] lx_d, ly_d, lf_d, ltx_d, lty_d, ltf_d;
  logic [CNT_W-1:0] ox_q, oy_q, of_q, ox_d, oy_d, of_d;
  logic [CNT_W-1:0] pox_q, poy_q, pof_q, pox_d, poy_d, pof_d;
  logic             cs_q, ds_q, busy_q, done_q, err_q;
  logic             cs_d, ds_d, busy_d, done_d, err_d;
  logic             dims_ok;
  logic [CNT_W:0]   ox_sum, oy_sum, of_sum, rem_x, rem_y, rem_f;

  assign dims_ok = (|out_x) && (|out_y) && (|out_f) && (|tile_x) && (|tile_y) && (|tile_f);

  // One extra bit so origin + tile never wraps even for dims at 2^CNT_W-1
  assign ox_sum = {1'b0, ox_q} + {1'b0, ltx};
  assign oy_sum = {1'b0, oy_q} + {1'b0, lty};
  assign of_sum = {1'b0, of_q} + {1'b0, ltf};
  assign rem_x  = {1'b0, lx} - {1'b0, ox_q} + ONE_W;
  assign rem_y  = {1'b0, ly} - {1'b0, oy_q} + ONE_W;
  assign rem_f  = {1'b0, lf} - {1'b0, of_q} + ONE_W;

  always_comb begin
    state_d = state;
    lx_d = lx;  ly_d = ly;  lf_d = lf;
    ltx_d = ltx; lty_d = lty; ltf_d = ltf;
    ox_d = ox_q; oy_d = oy_q; of_d = of_q;
    pox_d = pox_q; poy_d = poy_q; pof_d = pof_q;
    cs_d = 1'b0; ds_d = 1'b0; done_d = 1'b0; err_d = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          if (dims_ok) begin
            lx_d = out_x;  ly_d = out_y;  lf_d = out_f;
            ltx_d = tile_x; lty_d = tile_y; ltf_d = tile_f;
            ox_d = ONE; oy_d = ONE; of_d = ONE;
            state_d = S_LOAD;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      S_LOAD: begin
        pox_d = ({1'b0, ltx} < rem_x) ? ltx : rem_x[CNT_W-1:0];
        poy_d = ({1'b0, lty} < rem_y) ? lty : rem_y[CNT_W-1:0];
        pof_d = ({1'b0, ltf} < rem_f) ? ltf : rem_f[CNT_W-1:0];
        cs_d = 1'b1;
        state_d = S_COMPUTE;
      end
      S_COMPUTE: begin
        if (tile.compute_done) begin
          ds_d = 1'b1;
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (tile.out_done) state_d = S_ADVANCE;
      end
      S_ADVANCE: begin
        // Origins are left untouched on the last tile so cur_* stays on it
        if (of_sum <= {1'b0, lf}) begin
          of_d = of_sum[CNT_W-1:0];
          state_d = S_LOAD;
        end else if (ox_sum <= {1'b0, lx}) begin
          of_d = ONE;
          ox_d = ox_sum[CNT_W-1:0];
          state_d = S_LOAD;
        end else if (oy_sum <= {1'b0, ly}) begin
          of_d = ONE;
          ox_d = ONE;
          oy_d = oy_sum[CNT_W-1:0];
          state_d = S_LOAD;
        end else begin
          done_d = 1'b1;
          state_d = S_FIN;
        end
      end
      S_FIN: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= S_IDLE;
      lx <= '0; ly <= '0; lf <= '0;
      ltx <= '0; lty <= '0; ltf <= '0;
      ox_q <= ONE; oy_q <= ONE; of_q <= ONE;
      pox_q <= '0; poy_q <= '0; pof_q <= '0;
      cs_q <= 1'b0; ds_q <= 1'b0; busy_q <= 1'b0; done_q <= 1'b0; err_q <= 1'b0;
    end else begin
      state <= state_d;
      lx <= lx_d; ly <= ly_d; lf <= lf_d;
      ltx <= ltx_d; lty <= lty_d; ltf <= ltf_d;
      ox_q <= ox_d; oy_q <= oy_d; of_q <= of_d;
      pox_q <= pox_d; poy_q <= poy_d; pof_q <= pof_d;
      cs_q <= cs_d; ds_q <= ds_d; busy_q <= busy_d; done_q <= done_d; err_q <= err_d;
    end
  end

  assign tile.cur_ox_start  = ox_q;
  assign tile.cur_oy_start  = oy_q;
  assign tile.cur_of_start  = of_q;
  assign tile.cur_pox       = pox_q;
  assign tile.cur_poy       = poy_q;
  assign tile.cur_pof       = pof_q;
  assign tile.compute_start = cs_q;
  assign tile.drain_start   = ds_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign cfg_err = err_q;

`ifdef CONV_SEQ_PERF_CNT_EN
  logic [PERF_W-1:0] pb_q, pd_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      pb_q <= '0;
      pd_q <= '0;
    end else if (state == S_IDLE && start && dims_ok) begin
      pb_q <= '0;
      pd_q <= '0;
    end else begin
      if (busy_q && !(&pb_q)) pb_q <= pb_q + 1'b1;
      if (state == S_DRAIN && !(&pd_q)) pd_q <= pd_q + 1'b1;
    end
  end

  assign perf_busy_cycles  = pb_q;
  assign perf_drain_cycles = pd_q;
`endif

endmodule

// File: tb/tb_conv_out_tile_sequencer.sv
// tb/tb_conv_out_tile_sequencer.sv - directed self-checking bench for conv_out_tile_sequencer
module tb_conv_out_tile_sequencer;
  logic        clk, reset, start;
  logic [15:0] out_x, out_y, out_f, tile_x, tile_y, tile_f;
  logic        busy, done, cfg_err;
`ifdef CONV_SEQ_PERF_CNT_EN
  logic [31:0] perf_b, perf_d;
`endif

  conv_out_tile_sequencer_if #(.CNT_W(16)) tif ();

  conv_out_tile_sequencer #(.CNT_W(16), .PERF_W(32)) dut (
    .clk(clk), .reset(reset), .start(start),
    .out_x(out_x), .out_y(out_y), .out_f(out_f),
    .tile_x(tile_x), .tile_y(tile_y), .tile_f(tile_f),
    .tile(tif),
    .busy(busy), .done(done), .cfg_err(cfg_err)
`ifdef CONV_SEQ_PERF_CNT_EN
    , .perf_busy_cycles(perf_b), .perf_drain_cycles(perf_d)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  int t_ox[16], t_oy[16], t_of[16], t_px[16], t_py[16], t_pf[16];
  int g_ntiles, g_ndone, g_done_cyc, g_rst_hit;
  int r_busy, r_ox, r_oy, r_of, r_px, r_py, r_pf, r_cs, r_ds, r_done;

  task automatic start_layer(input int ox, input int oy, input int of, input int tx, input int ty, input int tf);
    @(negedge clk);
    out_x = 16'(ox); out_y = 16'(oy); out_f = 16'(of);
    tile_x = 16'(tx); tile_y = 16'(ty); tile_f = 16'(tf);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Responds to compute_start/drain_start after cdly/ddly cycles and records each tile
  task automatic walk(input int cdly, input int ddly, input int maxcyc, input int abuse_tile, input int reset_tile);
    int cw, dw, post;
    bit fin, ab_now, rst_pend;
    cw = -1; dw = -1; fin = 0; ab_now = 0; rst_pend = 0;
    g_ntiles = 0; g_ndone = 0; g_done_cyc = -1; g_rst_hit = 0;
    for (int i = 0; i < maxcyc && !fin; i++) begin
      @(negedge clk);
      tif.compute_done = 1'b0; tif.out_done = 1'b0; start = 1'b0;
      if (rst_pend) begin
        r_busy = int'(busy); r_done = int'(done);
        r_ox = int'(tif.cur_ox_start); r_oy = int'(tif.cur_oy_start); r_of = int'(tif.cur_of_start);
        r_px = int'(tif.cur_pox); r_py = int'(tif.cur_poy); r_pf = int'(tif.cur_pof);
        r_cs = int'(tif.compute_start); r_ds = int'(tif.drain_start);
        reset = 1'b1;
        g_rst_hit = 1;
        fin = 1;
      end else if (done) begin
        g_ndone++;
        g_done_cyc = i + 2;
        fin = 1;
      end else begin
        if (ab_now) begin
          start = 1'b1;
          tif.out_done = 1'b1;
          ab_now = 0;
        end
        if (tif.compute_start) begin
          if (g_ntiles < 16) begin
            t_ox[g_ntiles] = int'(tif.cur_ox_start); t_oy[g_ntiles] = int'(tif.cur_oy_start);
            t_of[g_ntiles] = int'(tif.cur_of_start);
            t_px[g_ntiles] = int'(tif.cur_pox); t_py[g_ntiles] = int'(tif.cur_poy);
            t_pf[g_ntiles] = int'(tif.cur_pof);
          end
          if (g_ntiles == abuse_tile) ab_now = 1;
          g_ntiles++;
          cw = cdly;
        end
        if (tif.drain_start) begin
          dw = ddly;
          if (g_ntiles >= 1 && g_ntiles <= 16) begin
            checks++;
            if (int'(tif.cur_ox_start) !== t_ox[g_ntiles-1] || int'(tif.cur_of_start) !== t_of[g_ntiles-1] ||
                int'(tif.cur_pof) !== t_pf[g_ntiles-1]) begin
              errors++;
              $display("FAIL tile_stable tile=%0d got ox=%0d of=%0d pof=%0d want ox=%0d of=%0d pof=%0d",
                       g_ntiles-1, tif.cur_ox_start, tif.cur_of_start, tif.cur_pof,
                       t_ox[g_ntiles-1], t_of[g_ntiles-1], t_pf[g_ntiles-1]);
            end
          end
          if (g_ntiles - 1 == reset_tile) begin
            reset = 1'b0;
            rst_pend = 1;
          end
        end
        if (cw == 0) begin tif.compute_done = 1'b1; cw = -1; end
        else if (cw > 0) cw--;
        if (dw == 0) begin tif.out_done = 1'b1; dw = -1; end
        else if (dw > 0) dw--;
      end
    end
    checks++;
    if (!fin) begin
      errors++;
      $display("FAIL walk_timeout got no done within %0d cycles, want done", maxcyc);
    end
    tif.compute_done = 1'b0; tif.out_done = 1'b0; start = 1'b0; reset = 1'b1;
    post = (reset_tile >= 0) ? 20 : 3;
    for (int i = 0; i < post; i++) begin
      @(negedge clk);
      if (done) g_ndone++;
    end
  endtask

  task automatic test_reset;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || cfg_err !== 1'b0 || tif.compute_start !== 1'b0 || tif.drain_start !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctrl got busy=%b done=%b cfg_err=%b cs=%b ds=%b want all 0",
               busy, done, cfg_err, tif.compute_start, tif.drain_start);
    end
    checks++;
    if (tif.cur_ox_start !== 16'd1 || tif.cur_oy_start !== 16'd1 || tif.cur_of_start !== 16'd1) begin
      errors++;
      $display("FAIL reset_origin got %0d,%0d,%0d want 1,1,1", tif.cur_ox_start, tif.cur_oy_start, tif.cur_of_start);
    end
    checks++;
    if (tif.cur_pox !== 16'd0 || tif.cur_poy !== 16'd0 || tif.cur_pof !== 16'd0) begin
      errors++;
      $display("FAIL reset_size got %0d,%0d,%0d want 0,0,0", tif.cur_pox, tif.cur_poy, tif.cur_pof);
    end
  endtask

  task automatic test_tile_walk(input int abuse_tile);
    int e_ox[8] = '{1, 1, 5, 5, 1, 1, 5, 5};
    int e_oy[8] = '{1, 1, 1, 1, 5, 5, 5, 5};
    int e_of[8] = '{1, 33, 1, 33, 1, 33, 1, 33};
    start_layer(8, 8, 64, 4, 4, 32);
    walk(5, 5, 400, abuse_tile, -1);
    checks++;
    if (g_ntiles !== 8 || g_ndone !== 1) begin
      errors++;
      $display("FAIL walk8_count got tiles=%0d dones=%0d want 8 and 1", g_ntiles, g_ndone);
    end
    checks++;
    if (g_done_cyc !== 113) begin
      errors++;
      $display("FAIL walk8_latency got done at %0d want 113", g_done_cyc);
    end
    for (int t = 0; t < 8; t++) begin
      checks++;
      if (t_ox[t] !== e_ox[t] || t_oy[t] !== e_oy[t] || t_of[t] !== e_of[t] ||
          t_px[t] !== 4 || t_py[t] !== 4 || t_pf[t] !== 32) begin
        errors++;
        $display("FAIL walk8_tile%0d got (%0d,%0d,%0d) size %0d,%0d,%0d want (%0d,%0d,%0d) size 4,4,32",
                 t, t_ox[t], t_oy[t], t_of[t], t_px[t], t_py[t], t_pf[t], e_ox[t], e_oy[t], e_of[t]);
      end
    end
  endtask

  task automatic test_edge_clip;
    int e_ox[8] = '{1, 1, 5, 5, 1, 1, 5, 5};
    int e_oy[8] = '{1, 1, 1, 1, 5, 5, 5, 5};
    int e_of[8] = '{1, 33, 1, 33, 1, 33, 1, 33};
    int e_px[8] = '{4, 4, 2, 2, 4, 4, 2, 2};
    int e_py[8] = '{4, 4, 4, 4, 1, 1, 1, 1};
    int e_pf[8] = '{32, 8, 32, 8, 32, 8, 32, 8};
    start_layer(6, 5, 40, 4, 4, 32);
    walk(2, 3, 400, -1, -1);
    checks++;
    if (g_ntiles !== 8 || g_ndone !== 1) begin
      errors++;
      $display("FAIL clip_count got tiles=%0d dones=%0d want 8 and 1", g_ntiles, g_ndone);
    end
    for (int t = 0; t < 8; t++) begin
      checks++;
      if (t_ox[t] !== e_ox[t] || t_oy[t] !== e_oy[t] || t_of[t] !== e_of[t] ||
          t_px[t] !== e_px[t] || t_py[t] !== e_py[t] || t_pf[t] !== e_pf[t]) begin
        errors++;
        $display("FAIL clip_tile%0d got (%0d,%0d,%0d) size %0d,%0d,%0d want (%0d,%0d,%0d) size %0d,%0d,%0d",
                 t, t_ox[t], t_oy[t], t_of[t], t_px[t], t_py[t], t_pf[t],
                 e_ox[t], e_oy[t], e_of[t], e_px[t], e_py[t], e_pf[t]);
      end
    end
  endtask

  task automatic test_same_cycle;
    start_layer(1, 1, 1, 1, 1, 1);
    walk(0, 0, 50, -1, -1);
    checks++;
    if (g_done_cyc !== 5 || g_ndone !== 1 || g_ntiles !== 1) begin
      errors++;
      $display("FAIL same_cycle got done at %0d dones=%0d tiles=%0d want 5, 1, 1", g_done_cyc, g_ndone, g_ntiles);
    end
    checks++;
    if (t_px[0] !== 1 || t_py[0] !== 1 || t_pf[0] !== 1) begin
      errors++;
      $display("FAIL same_cycle_size got %0d,%0d,%0d want 1,1,1", t_px[0], t_py[0], t_pf[0]);
    end
  endtask

  task automatic test_config_error;
    @(negedge clk);
    out_x = 16'd4; out_y = 16'd4; out_f = 16'd4;
    tile_x = 16'd2; tile_y = 16'd2; tile_f = 16'd0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checks++;
    if (cfg_err !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL cfg_err_pulse got cfg_err=%b busy=%b want 1 and 0", cfg_err, busy);
    end
    @(negedge clk);
    checks++;
    if (cfg_err !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL cfg_err_clear got cfg_err=%b busy=%b want 0 and 0", cfg_err, busy);
    end
    start_layer(2, 1, 1, 1, 1, 1);
    walk(1, 1, 100, -1, -1);
    checks++;
    if (g_ntiles !== 2 || g_ndone !== 1 || t_ox[1] !== 2) begin
      errors++;
      $display("FAIL cfg_recover got tiles=%0d dones=%0d ox1=%0d want 2, 1, 2", g_ntiles, g_ndone, t_ox[1]);
    end
  endtask

  task automatic test_abuse_reset;
    test_tile_walk(1);
    start_layer(8, 8, 64, 4, 4, 32);
    walk(5, 5, 400, -1, 2);
    checks++;
    if (g_rst_hit !== 1 || g_ntiles !== 3 || g_ndone !== 0) begin
      errors++;
      $display("FAIL reset_mid got hit=%0d tiles=%0d dones=%0d want 1, 3, 0", g_rst_hit, g_ntiles, g_ndone);
    end
    checks++;
    if (r_busy !== 0 || r_done !== 0 || r_cs !== 0 || r_ds !== 0 ||
        r_ox !== 1 || r_oy !== 1 || r_of !== 1 || r_px !== 0 || r_py !== 0 || r_pf !== 0) begin
      errors++;
      $display("FAIL reset_mid_vals got busy=%0d done=%0d cs=%0d ds=%0d org=%0d,%0d,%0d size=%0d,%0d,%0d want 0 0 0 0 1,1,1 0,0,0",
               r_busy, r_done, r_cs, r_ds, r_ox, r_oy, r_of, r_px, r_py, r_pf);
    end
    start_layer(1, 1, 1, 1, 1, 1);
    walk(0, 0, 50, -1, -1);
    checks++;
    if (g_ndone !== 1 || g_done_cyc !== 5) begin
      errors++;
      $display("FAIL reset_recover got dones=%0d done at %0d want 1 and 5", g_ndone, g_done_cyc);
    end
  endtask

`ifdef CONV_SEQ_PERF_CNT_EN
  task automatic test_perf;
    start_layer(1, 1, 1, 1, 1, 1);
    walk(10, 6, 100, -1, -1);
    checks++;
    if (perf_d !== 32'd7) begin
      errors++;
      $display("FAIL perf_drain got %0d want 7", perf_d);
    end
    checks++;
    if (perf_b !== 32'd21) begin
      errors++;
      $display("FAIL perf_busy got %0d want 21", perf_b);
    end
  endtask
`endif

  initial begin
    reset = 1'b0; start = 1'b0;
    out_x = '0; out_y = '0; out_f = '0; tile_x = '0; tile_y = '0; tile_f = '0;
    tif.compute_done = 1'b0; tif.out_done = 1'b0;
    repeat (3) @(negedge clk);
    test_reset;
    reset = 1'b1;
    @(negedge clk);
    test_tile_walk(-1);
    test_edge_clip;
    test_same_cycle;
    test_config_error;
    test_abuse_reset;
`ifdef CONV_SEQ_PERF_CNT_EN
    test_perf;
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/conv_out_tile_sequencer.md
# conv_out_tile_sequencer

Top-level tile scheduler for the conv output path. Walks a full output feature map (OX × OY × OF) in tiles of up to tile_x × tile_y × tile_f. For each tile it:
- presents the tile origin and clipped tile size to the conv core and conv output handler;
- starts the compute;
- waits for quantization to finish, then starts the output drain;
- waits for the drain to end before advancing.

Tile origins are 1-based, matching the `cur_*_start` convention of the conv output handler.

## Interface
Parameters:
- CNT_W, 16, width of all dimension/start/size fields
- PERF_W, 32, width of perf counters (used only with CONV_SEQ_PERF_CNT_EN)

Ports:
- clk  in  1  single clock, all logic posedge
- reset  in  1  synchronous, active-low: reset==0 at a posedge resets the block
- start  in  1  begin a layer; sampled only in IDLE
- out_x, out_y, out_f  in  CNT_W  layer output width/height/channels; sampled on accepted start
- tile_x, tile_y, tile_f  in  CNT_W  max tile size per dimension; sampled on accepted start
- compute_done  in  1  one-cycle pulse from conv core: tile compute and quantize complete
- out_done  in  1  one-cycle pulse: drain complete (conv_out_add_end of handler)
- cur_ox_start, cur_oy_start, cur_of_start  out  CNT_W  1-based tile origin
- cur_pox, cur_poy, cur_pof  out  CNT_W  clipped tile size
- compute_start  out  1  one-cycle pulse: start tile compute
- drain_start  out  1  one-cycle pulse to handler's quantify_add_end
- busy  out  1  layer in progress
- done  out  1  one-cycle pulse: last tile drained
- cfg_err  out  1  one-cycle pulse: start rejected (zero dimension)

## Operation
- States: IDLE, LOAD, COMPUTE, DRAIN, ADVANCE, FIN.
- **IDLE**
  - If start==1 and all six dims are nonzero: latch the dims, set the origin to (1,1,1), go to LOAD.
  - If start==1 and any dim is 0: pulse cfg_err next cycle and stay in IDLE.
- **LOAD**: register the outputs:
  - cur_pox = min(tile_x, out_x − cur_ox_start + 1); cur_poy and cur_pof analogous.
  - Go to COMPUTE.
- **COMPUTE**
  - compute_start=1 in the first COMPUTE cycle only.
  - Wait for compute_done, including on that first cycle, then go to DRAIN.
- **DRAIN**
  - drain_start=1 in the first DRAIN cycle only.
  - Wait for out_done, including on that first cycle, then go to ADVANCE.
- **ADVANCE**: loop order is of innermost, then ox, then oy outermost.
  - If cur_of_start + tile_f ≤ out_f: of += tile_f.
  - Else of = 1, and:
    - if cur_ox_start + tile_x ≤ out_x: ox += tile_x;
    - else ox = 1, and if cur_oy_start + tile_y ≤ out_y: oy += tile_y;
    - else (last tile) go to FIN.
  - Otherwise go to LOAD.
- **FIN**: done=1 for one cycle, then go to IDLE.
- busy=1 in every state except IDLE.
- Arithmetic is done in CNT_W+1 bits so the origin + tile comparison cannot wrap. Dims up to 2^CNT_W − 1 are legal.
- Ignored inputs:
  - start outside IDLE;
  - compute_done outside COMPUTE;
  - out_done outside DRAIN.
- compute_done and out_done together in COMPUTE: only compute_done acts. out_done is lost, and the bench must not drive this.
- Reset mid-layer: next cycle is IDLE with every output at its reset value. Any pending done/start pulses are dropped.
- Reset values:
  - cur_*_start = 1, cur_p* = 0;
  - compute_start, drain_start, busy, done, cfg_err = 0;
  - perf counters = 0.

## Timing
- All outputs are registered.
- Start accepted at cycle T:
  - LOAD at T+1;
  - cur_* valid from T+2;
  - compute_start high at T+2.
- cur_* stay stable from LOAD exit until the next ADVANCE exit, covering the whole compute and drain.
- compute_done at cycle C: drain_start at C+1.
- out_done at cycle D:
  - ADVANCE at D+1;
  - next tile's compute_start at D+3 (LOAD at D+2);
  - or done at D+2 if it was the last tile.
- Fixed overhead per tile is 3 cycles (ADVANCE, LOAD, COMPUTE entry), excluding the core and drain wait times.
- busy drops in the cycle after done.

## Configuration
- CONV_SEQ_PERF_CNT_EN defined: adds output ports perf_busy_cycles and perf_drain_cycles, each PERF_W bits.
  - perf_busy_cycles counts cycles with busy==1.
  - perf_drain_cycles counts cycles spent in DRAIN.
  - Both clear on accepted start, hold after FIN, and saturate at all-ones.
- Not defined: neither port nor its counters exist. All other behaviour is identical.

## Test plan
- **8-tile walk**: out 8×8×64, tile 4×4×32, core and handler respond 5 cycles after each pulse.
  - Expect 8 tiles, (ox,oy,of) order (1,1,1),(1,1,33),(5,1,1),(5,1,33),(1,5,1),(1,5,33),(5,5,1),(5,5,33).
  - Every tile has size 4,4,32; exactly one done.
- **Edge clipping**: out 6×5×40, tile 4×4×32.
  - Expect 8 tiles: pof sequence 32,8; pox 4,2; poy 4,1; of origins 1 then 33.
- **Same-cycle handshakes**: compute_done on the same cycle as compute_start, and out_done on the first drain cycle.
  - Expect a 1×1×1 layer done exactly 5 cycles after start is accepted.
- **Config error**: start with tile_f=0 → cfg_err pulse, busy stays 0; a later valid start proceeds normally.
- **Abuse and reset**:
  - Extra start and stray out_done during COMPUTE → ignored, tile sequence unchanged.
  - reset=0 during DRAIN of tile 3 → IDLE next cycle, all outputs at reset values, no done pulse.
- **Perf counters (CONV_SEQ_PERF_CNT_EN)**: 1×1×1 layer with a 10-cycle compute and a 7-cycle drain.
  - Expect perf_drain_cycles == 7 and perf_busy_cycles == 21.
